// File: rtl/bus_tx_fifo.sv
// Per-driver transmit queue feeding one arbiter port: host pushes, arbiter pops (FWFT head on D_pop).
// Optional statistics outputs (drop_cnt, hwm) are built only when BUS_TX_FIFO_STATS_EN is defined.
module bus_tx_fifo #(
    parameter int pckg_sz = 24,
    parameter int depth = 16,
    localparam int cnt_w = $clog2(depth + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [pckg_sz-1:0] wr_data,
    output logic               full,
    output logic               pndng,
    input  logic               pop,
    output logic [pckg_sz-1:0] D_pop,
    output logic [cnt_w-1:0]   count,
    output logic               ovf,
    output logic               unf
`ifdef BUS_TX_FIFO_STATS_EN
    ,
    output logic [15:0]        drop_cnt,
    output logic [cnt_w-1:0]   hwm
`endif
);

    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;

    logic [pckg_sz-1:0] mem [depth];
    logic [ptr_w-1:0]   rd_ptr;
    logic [ptr_w-1:0]   wr_ptr;
    logic [cnt_w-1:0]   count_next;
    logic               pop_ok;
    logic               wr_ok;
    logic               drop;

    assign pndng  = (count != '0);
    assign full   = (count == cnt_w'(depth));
    assign pop_ok = pop && pndng;
    // A full queue still takes a write when the head leaves in the same cycle.
    assign wr_ok  = wr_en && (!full || pop_ok);
    assign drop   = wr_en && full && !pop;
    assign D_pop  = pndng ? mem[rd_ptr] : '0;

    function automatic logic [ptr_w-1:0] ptr_inc(input logic [ptr_w-1:0] p);
        return (p == ptr_w'(depth - 1)) ? '0 : p + ptr_w'(1);
    endfunction

    always_comb begin
        count_next = count;
        if (wr_ok && !pop_ok) begin
            count_next = count + cnt_w'(1);
        end else if (!wr_ok && pop_ok) begin
            count_next = count - cnt_w'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
            unf    <= 1'b0;
        end else begin
            count <= count_next;
            ovf   <= drop;
            unf   <= pop && !pndng;
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Storage has no reset; stale entries are never visible because D_pop is gated by count.
    always_ff @(posedge clk) begin
        if (!reset && wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

`ifdef BUS_TX_FIFO_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt <= '0;
            hwm      <= '0;
        end else begin
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (count_next > hwm) begin
                hwm <= count_next;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_tx_fifo.sv
// Directed self-checking bench for bus_tx_fifo (depth 16, 24-bit packets).
// Define BUS_TX_FIFO_STATS_EN for both files to also check drop_cnt/hwm.
module tb_bus_tx_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [23:0] wr_data;
    logic        full;
    logic        pndng;
    logic        pop;
    logic [23:0] D_pop;
    logic [4:0]  count;
    logic        ovf;
    logic        unf;
`ifdef BUS_TX_FIFO_STATS_EN
    logic [15:0] drop_cnt;
    logic [4:0]  hwm;
`endif

    int errors = 0;
    int checks = 0;
    logic [23:0] model_q[$];
    logic [23:0] r;

    always #5 clk = ~clk;

    bus_tx_fifo #(.pckg_sz(24), .depth(16)) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .full(full),
        .pndng(pndng),
        .pop(pop),
        .D_pop(D_pop),
        .count(count),
        .ovf(ovf),
        .unf(unf)
`ifdef BUS_TX_FIFO_STATS_EN
        ,
        .drop_cnt(drop_cnt),
        .hwm(hwm)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0;
        pop   = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wr_en = 1'b0;
        pop   = 1'b0;
        wr_data = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst_pndng", 32'(pndng), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_dpop", 32'(D_pop), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_unf", 32'(unf), 0);

        // 1: single write then pop
        wr_en = 1'b1; wr_data = 24'h020008;
        step();
        idle();
        chk("t1_pndng", 32'(pndng), 1);
        chk("t1_dpop", 32'(D_pop), 32'h020008);
        chk("t1_count", 32'(count), 1);
        pop = 1'b1;
        step();
        idle();
        chk("t1_pop_pndng", 32'(pndng), 0);
        chk("t1_pop_dpop", 32'(D_pop), 0);
        chk("t1_pop_count", 32'(count), 0);
        chk("t1_pop_unf", 32'(unf), 0);

        // 2: fill to 16, then a dropped 17th write
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 24'(i);
            step();
        end
        chk("t2_full", 32'(full), 1);
        chk("t2_count", 32'(count), 16);
        chk("t2_ovf_before", 32'(ovf), 0);
        wr_data = 24'h000011;
        step();
        idle();
        chk("t2_ovf", 32'(ovf), 1);
        chk("t2_count_drop", 32'(count), 16);
        step();
        chk("t2_ovf_pulse", 32'(ovf), 0);
        chk("t2_head_stable", 32'(D_pop), 1);

        // 3: write+pop on full queue
        wr_en = 1'b1; wr_data = 24'hAA0017; pop = 1'b1;
        step();
        idle();
        chk("t3_count", 32'(count), 16);
        chk("t3_full", 32'(full), 1);
        chk("t3_dpop", 32'(D_pop), 2);
        chk("t3_ovf", 32'(ovf), 0);
        for (int i = 2; i <= 17; i++) begin
            chk("t3_drain", 32'(D_pop), (i == 17) ? 32'hAA0017 : 32'(i));
            pop = 1'b1;
            step();
        end
        idle();
        chk("t3_empty", 32'(count), 0);
        chk("t3_unf", 32'(unf), 0);

        // 4: underflow, then write+pop on empty
        pop = 1'b1;
        step();
        idle();
        chk("t4_unf", 32'(unf), 1);
        chk("t4_count", 32'(count), 0);
        step();
        chk("t4_unf_pulse", 32'(unf), 0);
        wr_en = 1'b1; wr_data = 24'h123456; pop = 1'b1;
        step();
        idle();
        chk("t4_wp_count", 32'(count), 1);
        chk("t4_wp_unf", 32'(unf), 1);
        chk("t4_wp_dpop", 32'(D_pop), 32'h123456);
        pop = 1'b1;
        step();
        idle();
        chk("t4_drain", 32'(count), 0);

        // 5: 40 interleaved write/pop pairs with three packets in flight
        for (int i = 0; i < 3; i++) begin
            r = 24'($urandom);
            model_q.push_back(r);
            wr_en = 1'b1; wr_data = r;
            step();
        end
        idle();
        for (int i = 0; i < 40; i++) begin
            chk("t5_order", 32'(D_pop), 32'(model_q[0]));
            r = 24'($urandom);
            wr_en = 1'b1; wr_data = r; pop = 1'b1;
            step();
            void'(model_q.pop_front());
            model_q.push_back(r);
            chk("t5_count", 32'(count), 3);
        end
        idle();
        while (model_q.size() > 0) begin
            chk("t5_tail", 32'(D_pop), 32'(model_q[0]));
            void'(model_q.pop_front());
            pop = 1'b1;
            step();
        end
        idle();
        chk("t5_empty", 32'(pndng), 0);

`ifdef BUS_TX_FIFO_STATS_EN
        chk("stats_drop", 32'(drop_cnt), 1);
        chk("stats_hwm", 32'(hwm), 16);
`endif

        // 6: reset with queued data and simultaneous wr_en/pop
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 24'h050000 + 24'(i);
            step();
        end
        idle();
        chk("t6_loaded", 32'(count), 5);
        reset = 1'b1; wr_en = 1'b1; pop = 1'b1; wr_data = 24'h0F0F0F;
        step();
        reset = 1'b0;
        idle();
        chk("t6_pndng", 32'(pndng), 0);
        chk("t6_count", 32'(count), 0);
        chk("t6_dpop", 32'(D_pop), 0);
        chk("t6_full", 32'(full), 0);
`ifdef BUS_TX_FIFO_STATS_EN
        chk("t6_drop", 32'(drop_cnt), 0);
        chk("t6_hwm", 32'(hwm), 0);
`endif
        wr_en = 1'b1; wr_data = 24'h0ABCDE;
        step();
        idle();
        chk("t6_after_dpop", 32'(D_pop), 32'h0ABCDE);
        chk("t6_after_count", 32'(count), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
